// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversample sample/decide points,
// frame-format defaults shared with the transmitter, and the 3-sample vote helper.
package uart_pkg;

    localparam int unsigned DATA_BITS_DEF  = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    localparam int unsigned SAMPLE_PT_A    = 7;
    localparam int unsigned SAMPLE_PT_B    = 8;
    localparam int unsigned SAMPLE_PT_C    = 9;
    localparam int unsigned DECIDE_PT      = 15;
    localparam int unsigned STOP_DECIDE_PT = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte stream toward the register block: data, valid/ready handshake
// and per-byte status.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF
) ();

    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_frame_err;
    logic                 o_overrun;

    modport master (
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_overrun,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_overrun,
        output i_ready
    );

endinterface

// File: rtl/uart_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous input; resets to the idle-high
// line level so a reset never looks like a start edge.
module uart_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled start/data/stop recovery with 3-sample majority
// vote, single-entry output holding register, framing-error and overrun reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_rx,
    uart_rx_if.master  io_bus,
    output logic       o_busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_SAMPLE_A = CNT_W'(SAMPLE_PT_A);
    localparam logic [CNT_W-1:0] CNT_SAMPLE_B = CNT_W'(SAMPLE_PT_B);
    localparam logic [CNT_W-1:0] CNT_SAMPLE_C = CNT_W'(SAMPLE_PT_C);
    localparam logic [CNT_W-1:0] CNT_DECIDE   = CNT_W'(DECIDE_PT);
    localparam logic [CNT_W-1:0] CNT_STOP_DEC = CNT_W'(STOP_DECIDE_PT);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

    logic                 w_rx;

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [2:0]           r_samp;
    logic [2:0]           w_samp_nxt;
    logic                 r_armed;
    logic                 w_armed_nxt;

    logic                 w_maj_live;
    logic                 w_maj_all;
    logic                 w_frame_done;
    logic                 w_stop_bit;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    uart_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rx)
    );

    // At the cnt-9 decision points the third sample is the live line value.
    assign w_maj_live = majority3(r_samp[0], r_samp[1], w_rx);
    assign w_maj_all  = majority3(r_samp[0], r_samp[1], r_samp[2]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_samp_nxt   = r_samp;
        w_armed_nxt  = r_armed;
        w_frame_done = 1'b0;
        w_stop_bit   = 1'b0;

        if (i_tick) begin
            if (r_state != ST_IDLE) begin
                if (r_cnt == CNT_SAMPLE_A) w_samp_nxt[0] = w_rx;
                if (r_cnt == CNT_SAMPLE_B) w_samp_nxt[1] = w_rx;
                if (r_cnt == CNT_SAMPLE_C) w_samp_nxt[2] = w_rx;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_rx) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        w_state_nxt = ST_START;
                        w_cnt_nxt   = '0;
                        w_armed_nxt = 1'b0;
                    end
                end
                ST_START: begin
                    if ((r_cnt == CNT_SAMPLE_C) && w_maj_live) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_DECIDE) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CNT_DECIDE) begin
                        w_shift_nxt = {w_maj_all, r_shift[DATA_BITS-1:1]};
                        w_cnt_nxt   = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = ST_STOP;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == CNT_STOP_DEC) begin
                        w_frame_done = 1'b1;
                        w_stop_bit   = w_maj_live;
                        w_state_nxt  = ST_IDLE;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_samp  <= '1;
            r_armed <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_samp  <= w_samp_nxt;
            r_armed <= w_armed_nxt;
        end
    end

    // A completing frame may load in the same cycle the consumer drains the old byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_frame_done) begin
                if (!r_valid || io_bus.i_ready) begin
                    r_data      <= r_shift;
                    r_frame_err <= ~w_stop_bit;
                    r_valid     <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && io_bus.i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign io_bus.o_data      = r_data;
    assign io_bus.o_valid     = r_valid;
    assign io_bus.o_frame_err = r_frame_err;
    assign io_bus.o_overrun   = r_overrun;
    assign o_busy             = (r_state != ST_IDLE);

endmodule
